oursring_rr_req_arb: RTL and testbench
======================================

OURSRING_RR_REQ_ARB -- requirements
Module: oursring_rr_req_arb

Interface
REQ-001 Parameter N_IN_PORT, default 3, number of master (input) ports; legal range 2..16.
REQ-002 Derived localparam SEL_W = $clog2(N_IN_PORT), width of the select outputs.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rstn  input  1  asynchronous active-low reset.
REQ-005 i_awvalid, i_wvalid, i_wlast, i_arvalid  input  N_IN_PORT  per-port AW/W/AR valids and W last.
REQ-006 i_awready, i_wready, i_arready  output  N_IN_PORT  per-port readies.
REQ-007 o_awready, o_wready, o_arready  input  1  downstream readies.
REQ-008 o_awvalid, o_wvalid, o_wlast, o_arvalid  output  1  downstream valids and last.
REQ-009 o_w_sel, o_ar_sel  output  SEL_W  granted port index for the external AW/W and AR payload muxes.
REQ-010 o_busy_w  output  1  high while the W state machine is in BURST.

Function
REQ-011 W channel SHALL be a two-state FSM: IDLE, BURST.
REQ-012 IDLE: candidate = first port p, searched from w_ptr upward modulo N_IN_PORT, with i_awvalid[p] & i_wvalid[p]; o_awvalid = o_wvalid = candidate exists; o_w_sel = p; o_wlast = i_wlast[p].
REQ-013 IDLE: i_awready[p] = i_wready[p] = o_awready & o_wready; AW and W SHALL handshake in the same cycle only.
REQ-014 IDLE handshake with i_wlast[p]=0 -> BURST, lock = p; with i_wlast[p]=1 -> stay IDLE, w_ptr <= p+1 mod N_IN_PORT.
REQ-015 IDLE, o_awvalid high and handshake not taken -> aw_hold set with held index p; while aw_hold is set, o_w_sel SHALL stay p regardless of other ports' valids, until handshake.
REQ-016 BURST: o_awvalid = 0; o_wvalid = i_wvalid[lock]; o_wlast = i_wlast[lock]; o_w_sel = lock; i_wready[lock] = o_wready; all other readies 0.
REQ-017 BURST handshake with i_wlast[lock]=1 -> IDLE, w_ptr <= lock+1 mod N_IN_PORT; non-last beats stay in BURST.
REQ-018 AR: candidate = first p from ar_ptr upward with i_arvalid[p]; o_arvalid = |i_arvalid; o_ar_sel = p; i_arready[p] = o_arready.
REQ-019 AR unaccepted valid SHALL set ar_hold, freezing o_ar_sel until handshake; on handshake ar_ptr <= p+1 mod N_IN_PORT, ar_hold cleared.
REQ-020 At most one bit of each i_*ready SHALL be set in any cycle.
REQ-021 Grant path SHALL be combinational (zero-cycle latency); no o_*valid SHALL depend on any o_*ready.
REQ-022 AR and AW/W arbitration SHALL be independent; simultaneous AR and AW handshakes in one cycle SHALL both complete.
REQ-023 Wrap-around: pointer at N_IN_PORT-1 granting port N_IN_PORT-1 SHALL advance to 0.

Reset
REQ-024 rstn low SHALL asynchronously force state IDLE, w_ptr = ar_ptr = 0, lock = 0, aw_hold = ar_hold = 0.
REQ-025 While rstn low all i_*ready, o_*valid, o_wlast, o_busy_w SHALL be 0; o_w_sel, o_ar_sel SHALL be 0.
REQ-026 Reset mid-burst SHALL abandon the burst; first cycle after release is IDLE with w_ptr = 0.

Configuration
REQ-027 Macro OURSRING_RR_ARB_EN defined: round-robin pointer behaviour of REQ-012..REQ-019.
REQ-028 Macro undefined: w_ptr and ar_ptr SHALL be held at 0 (fixed priority, port 0 highest); hold, lock and burst behaviour unchanged.

Verification
REQ-029 N=3, RR on, ports 0,1,2 each issue single-beat writes continuously, o_awready=o_wready=1 -> grants 0,1,2,0,1,2 in consecutive cycles.
REQ-030 Port 1 starts 4-beat burst, port 0 asserts AW+W during beat 2 -> port 0 readies 0 until port 1 last beat; o_busy_w high 3 cycles; port 0 granted next cycle.
REQ-031 Port 2 AR valid, o_arready=0 for 3 cycles, port 0 raises AR in cycle 2 -> o_ar_sel stays 2; handshake port 2 in cycle 4; ar_ptr=0.
REQ-032 AW valid on port 0 without W valid -> o_awvalid=0, i_awready[0]=0; W asserted next cycle -> joint handshake.
REQ-033 rstn pulsed low during beat 2 of a burst -> all readies/valids 0 immediately; after release IDLE, o_busy_w=0.
REQ-034 RR off, ports 0 and 2 continuously valid on AR, o_arready=1 -> port 0 granted every cycle, port 2 never.

Source files
------------

// File: rtl/oursring_rr_req_arb.sv
// oursring_rr_req_arb: AW/W and AR request arbiter for N_IN_PORT masters, combinational grant.
// Define OURSRING_RR_ARB_EN for round-robin pointers; undefined gives fixed priority (port 0 highest).
module oursring_rr_req_arb #(
  parameter int N_IN_PORT = 3,
  localparam int SEL_W = $clog2(N_IN_PORT)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_IN_PORT-1:0] i_awvalid,
  input  logic [N_IN_PORT-1:0] i_wvalid,
  input  logic [N_IN_PORT-1:0] i_wlast,
  input  logic [N_IN_PORT-1:0] i_arvalid,
  output logic [N_IN_PORT-1:0] i_awready,
  output logic [N_IN_PORT-1:0] i_wready,
  output logic [N_IN_PORT-1:0] i_arready,
  input  logic                 o_awready,
  input  logic                 o_wready,
  input  logic                 o_arready,
  output logic                 o_awvalid,
  output logic                 o_wvalid,
  output logic                 o_wlast,
  output logic                 o_arvalid,
  output logic [SEL_W-1:0]     o_w_sel,
  output logic [SEL_W-1:0]     o_ar_sel,
  output logic                 o_busy_w
);

`ifdef OURSRING_RR_ARB_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  localparam logic [0:0] W_IDLE  = 1'b0;
  localparam logic [0:0] W_BURST = 1'b1;

  logic [0:0]           w_state_q, w_state_d;
  logic [SEL_W-1:0]     w_ptr_q, w_ptr_d;
  logic [SEL_W-1:0]     ar_ptr_q, ar_ptr_d;
  logic [SEL_W-1:0]     lock_q, lock_d;
  logic                 aw_hold_q, aw_hold_d;
  logic [SEL_W-1:0]     aw_hold_idx_q, aw_hold_idx_d;
  logic                 ar_hold_q, ar_hold_d;
  logic [SEL_W-1:0]     ar_hold_idx_q, ar_hold_idx_d;

  logic [N_IN_PORT-1:0] aw_req;
  logic [SEL_W-1:0]     w_idx, ar_idx;
  logic [N_IN_PORT-1:0] awready_c, wready_c, arready_c;
  logic                 awvalid_c, wvalid_c, wlast_c, arvalid_c;
  logic [SEL_W-1:0]     w_sel_c;

  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] idx);
    if (32'(idx) == 32'(N_IN_PORT - 1)) return '0;
    else return idx + SEL_W'(1);
  endfunction

  // First requesting port at or after ptr, wrapping modulo N_IN_PORT.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_IN_PORT-1:0] req,
                                               input logic [SEL_W-1:0]     ptr);
    logic [SEL_W-1:0] pick;
    logic [SEL_W-1:0] kk;
    logic             hit;
    pick = '0;
    hit  = 1'b0;
    for (int unsigned i = 0; i < N_IN_PORT; i++) begin
      kk = SEL_W'((32'(ptr) + i) % 32'(N_IN_PORT));
      if (!hit && req[kk]) begin
        hit  = 1'b1;
        pick = kk;
      end
    end
    return pick;
  endfunction

  always_comb begin
    w_state_d     = w_state_q;
    w_ptr_d       = w_ptr_q;
    lock_d        = lock_q;
    aw_hold_d     = 1'b0;
    aw_hold_idx_d = aw_hold_idx_q;
    aw_req        = i_awvalid & i_wvalid;
    w_idx         = aw_hold_q ? aw_hold_idx_q : rr_pick(aw_req, w_ptr_q);
    awready_c     = '0;
    wready_c      = '0;
    awvalid_c     = 1'b0;
    wvalid_c      = 1'b0;
    wlast_c       = 1'b0;
    w_sel_c       = w_idx;
    case (w_state_q)
      W_IDLE: begin
        // AW and W are only offered together so both handshake in the same cycle.
        awvalid_c = aw_req[w_idx];
        wvalid_c  = aw_req[w_idx];
        wlast_c   = aw_req[w_idx] & i_wlast[w_idx];
        if (aw_req[w_idx]) begin
          awready_c[w_idx] = o_awready & o_wready;
          wready_c[w_idx]  = o_awready & o_wready;
          if (o_awready && o_wready) begin
            if (i_wlast[w_idx]) begin
              w_ptr_d = RR_EN ? next_ptr(w_idx) : '0;
            end else begin
              w_state_d = W_BURST;
              lock_d    = w_idx;
            end
          end else begin
            aw_hold_d     = 1'b1;
            aw_hold_idx_d = w_idx;
          end
        end
      end
      default: begin
        w_sel_c          = lock_q;
        wvalid_c         = i_wvalid[lock_q];
        wlast_c          = i_wlast[lock_q];
        wready_c[lock_q] = o_wready;
        if (i_wvalid[lock_q] && o_wready && i_wlast[lock_q]) begin
          w_state_d = W_IDLE;
          w_ptr_d   = RR_EN ? next_ptr(lock_q) : '0;
        end
      end
    endcase
  end

  always_comb begin
    ar_ptr_d      = ar_ptr_q;
    ar_idx        = ar_hold_q ? ar_hold_idx_q : rr_pick(i_arvalid, ar_ptr_q);
    arvalid_c     = i_arvalid[ar_idx];
    arready_c     = '0;
    ar_hold_d     = arvalid_c & ~o_arready;
    ar_hold_idx_d = ar_idx;
    if (arvalid_c) begin
      arready_c[ar_idx] = o_arready;
      if (o_arready) ar_ptr_d = RR_EN ? next_ptr(ar_idx) : '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state_q     <= W_IDLE;
      w_ptr_q       <= '0;
      ar_ptr_q      <= '0;
      lock_q        <= '0;
      aw_hold_q     <= 1'b0;
      aw_hold_idx_q <= '0;
      ar_hold_q     <= 1'b0;
      ar_hold_idx_q <= '0;
    end else begin
      w_state_q     <= w_state_d;
      w_ptr_q       <= w_ptr_d;
      ar_ptr_q      <= ar_ptr_d;
      lock_q        <= lock_d;
      aw_hold_q     <= aw_hold_d;
      aw_hold_idx_q <= aw_hold_idx_d;
      ar_hold_q     <= ar_hold_d;
      ar_hold_idx_q <= ar_hold_idx_d;
    end
  end

  // Outputs are gated by rstn so they read zero for the whole reset window.
  assign i_awready = {N_IN_PORT{rstn}} & awready_c;
  assign i_wready  = {N_IN_PORT{rstn}} & wready_c;
  assign i_arready = {N_IN_PORT{rstn}} & arready_c;
  assign o_awvalid = rstn & awvalid_c;
  assign o_wvalid  = rstn & wvalid_c;
  assign o_wlast   = rstn & wlast_c;
  assign o_arvalid = rstn & arvalid_c;
  assign o_w_sel   = {SEL_W{rstn}} & w_sel_c;
  assign o_ar_sel  = {SEL_W{rstn}} & ar_idx;
  assign o_busy_w  = rstn & (w_state_q == W_BURST);

endmodule

// File: tb/tb_oursring_rr_req_arb.sv
// Directed bench for oursring_rr_req_arb (N_IN_PORT=3); expectations follow OURSRING_RR_ARB_EN.
module tb_oursring_rr_req_arb;
  localparam int N = 3;

`ifdef OURSRING_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rstn;
  logic [N-1:0] i_awvalid, i_wvalid, i_wlast, i_arvalid;
  logic [N-1:0] i_awready, i_wready, i_arready;
  logic         o_awready, o_wready, o_arready;
  logic         o_awvalid, o_wvalid, o_wlast, o_arvalid, o_busy_w;
  logic [1:0]   o_w_sel, o_ar_sel;
  int           n_tests = 0;
  int           n_fail  = 0;

  always #5 clk = ~clk;

  oursring_rr_req_arb #(.N_IN_PORT(N)) dut (
    .clk(clk), .rstn(rstn),
    .i_awvalid(i_awvalid), .i_wvalid(i_wvalid), .i_wlast(i_wlast), .i_arvalid(i_arvalid),
    .i_awready(i_awready), .i_wready(i_wready), .i_arready(i_arready),
    .o_awready(o_awready), .o_wready(o_wready), .o_arready(o_arready),
    .o_awvalid(o_awvalid), .o_wvalid(o_wvalid), .o_wlast(o_wlast), .o_arvalid(o_arvalid),
    .o_w_sel(o_w_sel), .o_ar_sel(o_ar_sel), .o_busy_w(o_busy_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    i_awvalid = '0; i_wvalid = '0; i_wlast = '0; i_arvalid = '0;
  endtask

  initial begin
    // Reset with every input active: outputs must still read zero.
    rstn = 1'b0;
    i_awvalid = 3'b111; i_wvalid = 3'b111; i_wlast = 3'b111; i_arvalid = 3'b111;
    o_awready = 1'b1; o_wready = 1'b1; o_arready = 1'b1;
    #2;
    chk("rst_awready", 32'(i_awready), 0);
    chk("rst_wready",  32'(i_wready),  0);
    chk("rst_arready", 32'(i_arready), 0);
    chk("rst_valids",  32'({o_awvalid, o_wvalid, o_wlast, o_arvalid}), 0);
    chk("rst_busy",    32'(o_busy_w), 0);
    chk("rst_sels",    32'({o_w_sel, o_ar_sel}), 0);
    clear_in();
    tick(); tick();
    rstn = 1'b1;
    #1;

    // Continuous single-beat writes from all ports.
    i_awvalid = 3'b111; i_wvalid = 3'b111; i_wlast = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_w_sel",   32'(o_w_sel), RR ? 32'(i % 3) : 0);
      chk("rr_awready", 32'(i_awready), RR ? 32'(1 << (i % 3)) : 1);
      chk("rr_awvalid", 32'(o_awvalid), 1);
      tick();
    end
    clear_in();
    tick();

    // Port 1 four-beat burst; port 0 requests during beat 2.
    i_awvalid = 3'b010; i_wvalid = 3'b010; i_wlast = 3'b000;
    #1;
    chk("b1_sel",     32'(o_w_sel), 1);
    chk("b1_awready", 32'(i_awready), 32'b010);
    chk("b1_busy",    32'(o_busy_w), 0);
    tick();
    i_awvalid = 3'b001; i_wvalid = 3'b011;
    for (int b = 2; b <= 4; b++) begin
      i_wlast = (b == 4) ? 3'b010 : 3'b000;
      #1;
      chk("bn_busy",    32'(o_busy_w), 1);
      chk("bn_awvalid", 32'(o_awvalid), 0);
      chk("bn_sel",     32'(o_w_sel), 1);
      chk("bn_wready",  32'(i_wready), 32'b010);
      chk("bn_awready", 32'(i_awready), 0);
      chk("bn_wlast",   32'(o_wlast), (b == 4) ? 1 : 0);
      tick();
    end
    i_awvalid = 3'b001; i_wvalid = 3'b001; i_wlast = 3'b001;
    #1;
    chk("b5_busy",    32'(o_busy_w), 0);
    chk("b5_sel",     32'(o_w_sel), 0);
    chk("b5_awready", 32'(i_awready), 32'b001);
    tick();
    clear_in();

    // AW hold: port 2 stalled, then port 0 joins; select must not move.
    o_awready = 1'b0;
    i_awvalid = 3'b100; i_wvalid = 3'b100; i_wlast = 3'b100;
    #1;
    chk("h1_sel",     32'(o_w_sel), 2);
    chk("h1_awready", 32'(i_awready), 0);
    tick();
    i_awvalid = 3'b101; i_wvalid = 3'b101; i_wlast = 3'b101;
    #1;
    chk("h2_sel", 32'(o_w_sel), 2);
    tick();
    o_awready = 1'b1;
    #1;
    chk("h3_sel",     32'(o_w_sel), 2);
    chk("h3_awready", 32'(i_awready), 32'b100);
    tick();
    clear_in();

    // AW without W is not offered; W next cycle gives joint handshake.
    i_awvalid = 3'b001; i_wlast = 3'b001;
    #1;
    chk("aw_only_valid", 32'(o_awvalid), 0);
    chk("aw_only_ready", 32'(i_awready), 0);
    tick();
    i_wvalid = 3'b001;
    #1;
    chk("aw_w_valid",  32'(o_awvalid), 1);
    chk("aw_w_aready", 32'(i_awready), 32'b001);
    chk("aw_w_wready", 32'(i_wready),  32'b001);
    tick();
    clear_in();

    // AR hold: port 2 stalled three cycles, port 0 joins in cycle 2.
    o_arready = 1'b0;
    i_arvalid = 3'b100;
    #1;
    chk("ar1_sel",   32'(o_ar_sel), 2);
    chk("ar1_valid", 32'(o_arvalid), 1);
    chk("ar1_ready", 32'(i_arready), 0);
    tick();
    i_arvalid = 3'b101;
    #1;
    chk("ar2_sel", 32'(o_ar_sel), 2);
    tick();
    #1;
    chk("ar3_sel", 32'(o_ar_sel), 2);
    tick();
    // Cycle 4: AR handshake together with an AW/W handshake on port 1.
    o_arready = 1'b1;
    i_awvalid = 3'b010; i_wvalid = 3'b010; i_wlast = 3'b010;
    #1;
    chk("ar4_sel",     32'(o_ar_sel), 2);
    chk("ar4_arready", 32'(i_arready), 32'b100);
    chk("ar4_awready", 32'(i_awready), 32'b010);
    tick();
    i_awvalid = '0; i_wvalid = '0; i_wlast = '0;
    #1;
    chk("ar5_sel",     32'(o_ar_sel), 0);
    chk("ar5_arready", 32'(i_arready), 32'b001);
    tick();

    // Ports 0 and 2 continuously valid on AR.
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ar_pri_sel", 32'(o_ar_sel), (RR && (i % 2 == 0)) ? 2 : 0);
      chk("ar_pri_rdy", 32'(i_arready), (RR && (i % 2 == 0)) ? 32'b100 : 32'b001);
      tick();
    end
    clear_in();
    tick();

    // Reset pulsed during beat 2 of a port 0 burst.
    i_awvalid = 3'b001; i_wvalid = 3'b001; i_wlast = 3'b000;
    tick();
    i_awvalid = 3'b000;
    #1;
    chk("mr_busy_pre",   32'(o_busy_w), 1);
    chk("mr_wready_pre", 32'(i_wready), 32'b001);
    rstn = 1'b0;
    #1;
    chk("mr_wready", 32'(i_wready), 0);
    chk("mr_wvalid", 32'(o_wvalid), 0);
    chk("mr_busy",   32'(o_busy_w), 0);
    tick();
    rstn = 1'b1;
    #1;
    chk("mr_post_busy",   32'(o_busy_w), 0);
    chk("mr_post_wvalid", 32'(o_wvalid), 0);
    chk("mr_post_wready", 32'(i_wready), 0);
    i_awvalid = 3'b001; i_wlast = 3'b001;
    #1;
    chk("mr_idle_valid", 32'(o_awvalid), 1);
    chk("mr_idle_ready", 32'(i_awready), 32'b001);
    tick();
    clear_in();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
